// File: rtl/core_pkg.sv
// Shared core definitions used by the write-back stage.
//   wb_sel_e    : write-back source select (ALU, MEM, PC4, reserved)
//   F3_*        : load funct3 encodings
//   wb_state_e  : write-back stage FSM states
package core_pkg;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2,
      WB_RSV = 2'd3
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      COMMIT   = 2'd2
   } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Load data extraction and alignment/legality check (combinational).
//   funct3 : load type
//   off    : byte offset within the word (alu_result[1:0])
//   rdata  : raw word returned by data memory
//   data   : extracted, sign/zero-extended load value
//   fault  : misaligned access or illegal funct3
module load_extend
   import core_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] rdata,
   output logic [31:0] data,
   output logic        fault
);

   logic [7:0]  byte_val;
   logic [15:0] half_val;

   assign byte_val = rdata[{off, 3'b000} +: 8];
   assign half_val = rdata[{off[1], 4'b0000} +: 16];

   always_comb begin
      data  = '0;
      fault = 1'b0;
      case (funct3)
         F3_LB:  data = {{24{byte_val[7]}}, byte_val};
         F3_LBU: data = {24'd0, byte_val};
         F3_LH: begin
            data  = {{16{half_val[15]}}, half_val};
            fault = off[0];
         end
         F3_LHU: begin
            data  = {16'd0, half_val};
            fault = off[0];
         end
         F3_LW: begin
            data  = rdata;
            fault = (off != 2'd0);
         end
         default: fault = 1'b1;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: accepts an execute bundle, performs the load (if any)
// and drives the register-file write port.
//   clk, reset                 : clock, synchronous active-high reset
//   ex_valid / ex_ready        : upstream handshake
//   ex_alu_result, ex_pc_plus4 : result / load address and link value
//   ex_rd_addr, ex_reg_wen     : destination and write enable
//   ex_wb_sel, ex_funct3       : write-back source and load type
//   dmem_*                     : data memory request / response
//   rd_addr, wdata, RegWEn     : register-file write port
//   pend_valid, pend_rd        : destination of the held bundle
//   load_fault                 : one-cycle pulse on misaligned/illegal load
module wb_stage
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_pc_plus4,
   input  logic [4:0]  ex_rd_addr,
   input  logic        ex_reg_wen,
   input  logic [1:0]  ex_wb_sel,
   input  logic [2:0]  ex_funct3,
   output logic        dmem_req,
   output logic [31:0] dmem_addr,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic [4:0]  rd_addr,
   output logic [31:0] wdata,
   output logic        RegWEn,
   output logic        pend_valid,
   output logic [4:0]  pend_rd,
   output logic        load_fault
);

   wb_state_e   state;
   logic [4:0]  held_rd;
   logic        held_wen;
   logic [2:0]  held_f3;
   logic [1:0]  held_off;
   logic        accept;
   logic [2:0]  le_f3;
   logic [1:0]  le_off;
   logic [31:0] le_data;
   logic        le_fault;

   assign ex_ready = !reset && (state != WAIT_MEM);
   assign accept   = ex_valid && ex_ready;
   assign rd_addr  = held_rd;
   assign pend_rd  = held_rd;

   // One extractor serves both uses: fault check on the incoming bundle at
   // acceptance, and data extraction for the held bundle in WAIT_MEM.
   assign le_f3  = (state == WAIT_MEM) ? held_f3  : ex_funct3;
   assign le_off = (state == WAIT_MEM) ? held_off : ex_alu_result[1:0];

   load_extend u_load_extend (
      .funct3 (le_f3),
      .off    (le_off),
      .rdata  (dmem_rdata),
      .data   (le_data),
      .fault  (le_fault)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         held_rd    <= '0;
         held_wen   <= 1'b0;
         held_f3    <= '0;
         held_off   <= '0;
         dmem_req   <= 1'b0;
         dmem_addr  <= '0;
         wdata      <= '0;
         RegWEn     <= 1'b0;
         pend_valid <= 1'b0;
         load_fault <= 1'b0;
      end else if (state == WAIT_MEM) begin
         if (dmem_rvalid) begin
            state     <= COMMIT;
            dmem_req  <= 1'b0;
            dmem_addr <= '0;
            wdata     <= le_data;
            RegWEn    <= held_wen && (held_rd != 5'd0);
         end
      end else if (accept) begin
         held_rd    <= ex_rd_addr;
         held_wen   <= ex_reg_wen;
         held_f3    <= ex_funct3;
         held_off   <= ex_alu_result[1:0];
         pend_valid <= 1'b1;
         load_fault <= 1'b0;
         RegWEn     <= 1'b0;
         wdata      <= '0;
         state      <= COMMIT;
         case (ex_wb_sel)
            WB_ALU: begin
               wdata  <= ex_alu_result;
               RegWEn <= ex_reg_wen && (ex_rd_addr != 5'd0);
            end
            WB_PC4: begin
               wdata  <= ex_pc_plus4;
               RegWEn <= ex_reg_wen && (ex_rd_addr != 5'd0);
            end
            WB_MEM: begin
               if (le_fault) begin
                  load_fault <= 1'b1;
               end else begin
                  state     <= WAIT_MEM;
                  dmem_req  <= 1'b1;
                  dmem_addr <= {ex_alu_result[31:2], 2'b00};
               end
            end
            default: ;
         endcase
      end else begin
         state      <= IDLE;
         RegWEn     <= 1'b0;
         load_fault <= 1'b0;
         pend_valid <= 1'b0;
      end
   end

endmodule
